// File: rtl/muldiv_hilo_if.sv
// Handshake and result bundle between the EX-stage pipeline and muldiv_hilo_unit.
// The pipeline side drives requests (master); the unit drives status and HI/LO (slave).
interface muldiv_hilo_if #(
   parameter int WIDTH = 32
);
   logic             start_in;
   logic [2:0]       op_in;
   logic [WIDTH-1:0] data1_in;
   logic [WIDTH-1:0] data2_in;
   logic             busy_out;
   logic             done_out;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output start_in, op_in, data1_in, data2_in,
      input  busy_out, done_out, hi_out, lo_out
   );

   modport slave (
      input  start_in, op_in, data1_in, data2_in,
      output busy_out, done_out, hi_out, lo_out
   );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers (one bit per cycle).
// Define MULDIV_SIGNED_EN to give MULT/DIV two's-complement semantics; otherwise they act as MULTU/DIVU.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_hilo_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_e;
   typedef enum logic [2:0] {
      OP_MULTU = 3'd0, OP_DIVU = 3'd1, OP_MTHI = 3'd2,
      OP_MTLO  = 3'd3, OP_MULT = 3'd4, OP_DIV  = 3'd5
   } op_e;

   state_e             state, state_next;
   op_e                op;
   logic [CW-1:0]      count;
   logic               is_div;
   logic [WIDTH-1:0]   operand_b;     // multiplicand for multiply, divisor for divide
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   hi, lo, res_hi, res_lo;
   logic               done;
   logic               start_run, is_div_op;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     mul_sum, div_upper, div_diff;
   logic               div_ge;
`ifdef MULDIV_SIGNED_EN
   logic               sign1, sign2, neg_res, neg_rem;
`endif

   assign op        = op_e'(bus.op_in);
   assign start_run = bus.start_in && (op inside {OP_MULTU, OP_DIVU, OP_MULT, OP_DIV});
   assign is_div_op = op inside {OP_DIVU, OP_DIV};

   // Operand magnitudes latched at start; unsigned ops pass straight through.
   always_comb begin
      mag1 = bus.data1_in;
      mag2 = bus.data2_in;
`ifdef MULDIV_SIGNED_EN
      sign1 = (op inside {OP_MULT, OP_DIV}) && bus.data1_in[WIDTH-1];
      sign2 = (op inside {OP_MULT, OP_DIV}) && bus.data2_in[WIDTH-1];
      if (sign1) mag1 = -bus.data1_in;
      if (sign2) mag2 = -bus.data2_in;
`endif
   end

   // One iteration: acc = {partial, shifting operand}. Multiply adds into the top half and
   // shifts right; divide shifts left and subtracts the divisor when it fits.
   always_comb begin
      // NOTE: every signal driven here is given a value first so no latch is inferred.
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
      div_upper = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_upper - {1'b0, operand_b};
      div_ge    = div_upper >= {1'b0, operand_b};
      if (is_div)
         acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_upper[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
      else
         acc_step = {mul_sum, acc[WIDTH-1:1]};
   end

   always_comb begin
      {res_hi, res_lo} = acc_step;
`ifdef MULDIV_SIGNED_EN
      if (is_div) begin
         if (neg_res) res_lo = -acc_step[WIDTH-1:0];
         if (neg_rem) res_hi = -acc_step[2*WIDTH-1:WIDTH];
      end else if (neg_res) begin
         {res_hi, res_lo} = -acc_step;
      end
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_run) state_next = RUN;
         RUN:     if (count == LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath is cleared too, so an abandoned operation leaves nothing behind.
         count     <= '0;
         is_div    <= 1'b0;
         operand_b <= '0;
         acc       <= '0;
         hi        <= '0;
         lo        <= '0;
         done      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (bus.start_in && op == OP_MTHI) begin
               hi   <= bus.data1_in;
               done <= 1'b1;
            end
            if (bus.start_in && op == OP_MTLO) begin
               lo   <= bus.data1_in;
               done <= 1'b1;
            end
            if (start_run) begin
               count     <= '0;
               is_div    <= is_div_op;
               operand_b <= is_div_op ? mag2 : mag1;
               acc       <= {{WIDTH{1'b0}}, (is_div_op ? mag1 : mag2)};
`ifdef MULDIV_SIGNED_EN
               neg_res   <= sign1 ^ sign2;
               neg_rem   <= sign1 && is_div_op;
`endif
            end
         end else begin
            acc   <= acc_step;
            count <= count + CW'(1);
            if (count == LAST) begin
               hi   <= res_hi;
               lo   <= res_lo;
               done <= 1'b1;
            end
         end
      end
   end

   assign bus.busy_out = (state == RUN);
   assign bus.done_out = done;
   assign bus.hi_out   = hi;
   assign bus.lo_out   = lo;
endmodule
